// File: rtl/strobe_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : strobe_dec_pkg
// Purpose  : Shared state encoding, mode constants and helpers for the
//            timed one-hot strobe decoder.
// Revision : 1.0 - initial release
// ============================================================================
package strobe_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : strobe_dec_pkg
`default_nettype wire

// File: rtl/strobe_decoder_seq_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dec
// Purpose  : Combinational index-to-one-hot decoder with enable; all-zero
//            output when disabled.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_onehot
);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign o_onehot[i] = i_en && (i_sel == SEL_W'(i));
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/strobe_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : strobe_decoder_seq
// Purpose  : N-to-2^N decoder with registered outputs, timed HOLD strobes and
//            idle GAP, in single-shot (handshaked) or continuous scan mode.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_decoder_seq
    import strobe_dec_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int OUT_W    = 1 << SEL_W,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E,
    input  logic             mode,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    output logic [OUT_W-1:0] D,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = $clog2(max_int(HOLD_CYC, GAP_CYC) + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_e             r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [SEL_W-1:0]   r_sel_q,   w_sel_d;
    logic [OUT_W-1:0]   r_d_q,     w_d_d;
    logic               r_done_q,  w_done_d;

    logic               w_start;
    logic               w_next_strobe;
    logic [SEL_W-1:0]   w_start_sel;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_sel_d       = r_sel_q;
        w_start       = 1'b0;
        w_next_strobe = 1'b0;
        w_start_sel   = r_sel_q;

        case (r_state_q)
            ST_IDLE: begin
                if (E) begin
                    if (mode == MODE_SCAN) begin
                        w_start     = 1'b1;
                        w_start_sel = '0;
                    end else if (req_valid) begin
                        w_start     = 1'b1;
                        w_start_sel = req_sel;
                    end
                end
            end
            ST_HOLD: begin
                if (!E) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end else if (GAP_CYC > 0) begin
                    w_state_d = ST_GAP;
                    w_cnt_d   = c_GAP_LOAD;
                end else begin
                    w_next_strobe = 1'b1;
                end
            end
            ST_GAP: begin
                if (!E) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end else begin
                    w_next_strobe = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase

        // End of a strobe period: mode is only looked at here and in IDLE.
        if (w_next_strobe) begin
            if (mode == MODE_SCAN) begin
                w_start     = 1'b1;
                w_start_sel = r_sel_q + SEL_W'(1);
            end else begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        end

        if (w_start) begin
            w_state_d = ST_HOLD;
            w_cnt_d   = c_HOLD_LOAD;
            w_sel_d   = w_start_sel;
        end

        w_done_d = (w_state_d == ST_HOLD) && (w_cnt_d == '0);
    end

    onehot_dec #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .i_sel    (w_sel_d),
        .i_en     (w_state_d == ST_HOLD),
        .o_onehot (w_d_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_sel_q   <= '0;
            r_d_q     <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_sel_q   <= w_sel_d;
            r_d_q     <= w_d_d;
            r_done_q  <= w_done_d;
        end
    end

    assign req_ready = (r_state_q == ST_IDLE) && E && (mode == MODE_SINGLE);
    assign D         = r_d_q;
    assign cur_sel   = r_sel_q;
    assign busy      = (r_state_q != ST_IDLE);
    assign done      = r_done_q;

endmodule : strobe_decoder_seq
`default_nettype wire
